// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: owns the PC, waits MEM_LATENCY cycles per address,
// and delivers instruction/PC pairs to decode over a valid/ready handshake.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_instr;
    logic [31:0]      w_instr_nxt;
    logic [31:0]      r_if_pc;
    logic [31:0]      w_if_pc_nxt;
    logic [31:0]      r_fetch_count;
    logic [31:0]      w_fetch_count_nxt;

    logic             w_data_ok;
    logic             w_transfer;
    logic             w_capture;
    logic [31:0]      w_redirect_aligned;

    // Masking rather than slicing keeps the whole redirect bus in use.
    assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign w_data_ok  = (r_cnt == CNT_MAX);
    assign w_transfer = (r_state == ST_FULL) && id_ready;
    assign w_capture  = w_data_ok && ((r_state == ST_EMPTY) || id_ready) && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_EMPTY;
            r_pc          <= RESET_PC;
            r_cnt         <= '0;
            r_instr       <= '0;
            r_if_pc       <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_instr       <= w_instr_nxt;
            r_if_pc       <= w_if_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_if_pc_nxt       = r_if_pc;
        w_fetch_count_nxt = r_fetch_count;
        // Saturating settle counter: a stalled word stays ready for release.
        w_cnt_nxt         = w_data_ok ? r_cnt : r_cnt + CNT_W'(1);

        // A transfer coinciding with a redirect was still consumed by decode.
        if (w_transfer) begin
            w_fetch_count_nxt = r_fetch_count + 32'd1;
        end

        if (redirect_valid) begin
            w_pc_nxt    = w_redirect_aligned;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_EMPTY;
        end else if (w_capture) begin
            w_instr_nxt = imem_rdata;
            w_if_pc_nxt = r_pc;
            w_pc_nxt    = r_pc + 32'd4;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_FULL;
        end else if (w_transfer) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    assign imem_addr   = r_pc;
    assign if_valid    = (r_state == ST_FULL);
    assign if_instr    = r_instr;
    assign if_pc       = r_if_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: three instances cover the default
// configuration, PC wrap-around from the top of memory, and single-cycle latency.
module tb_ifetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   mem_word = 32'h11;
            32'h4:   mem_word = 32'h22;
            32'h8:   mem_word = 32'h33;
            default: mem_word = 32'hA000_0000 ^ addr;
        endcase
    endfunction

    // Instance A: MEM_LATENCY=3, RESET_PC=0
    logic rst_a = 1'b0, rv_a = 1'b0, rdy_a = 1'b0, valid_a;
    logic [31:0] rpc_a = '0, addr_a, rdata_a, instr_a, pc_a, fc_a;
    assign rdata_a = mem_word(addr_a);

    ifetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(3)) dut_a (
        .clk(clk), .rst_n(rst_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .if_valid(valid_a),
        .id_ready(rdy_a), .if_instr(instr_a), .if_pc(pc_a), .fetch_count(fc_a)
    );

    // Instance B: reset at the top word to exercise PC wrap
    logic rst_b = 1'b0, rv_b = 1'b0, rdy_b = 1'b0, valid_b;
    logic [31:0] rpc_b = '0, addr_b, rdata_b, instr_b, pc_b, fc_b;
    assign rdata_b = mem_word(addr_b);

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .if_valid(valid_b),
        .id_ready(rdy_b), .if_instr(instr_b), .if_pc(pc_b), .fetch_count(fc_b)
    );

    // Instance C: single-cycle memory
    logic rst_c = 1'b0, rv_c = 1'b0, rdy_c = 1'b0, valid_c;
    logic [31:0] rpc_c = '0, addr_c, rdata_c, instr_c, pc_c, fc_c;
    assign rdata_c = mem_word(addr_c);

    ifetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(1)) dut_c (
        .clk(clk), .rst_n(rst_c), .imem_addr(addr_c), .imem_rdata(rdata_c),
        .redirect_valid(rv_c), .redirect_pc(rpc_c), .if_valid(valid_c),
        .id_ready(rdy_c), .if_instr(instr_c), .if_pc(pc_c), .fetch_count(fc_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        tick();
        tick();
        tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", valid_a); end
        tests_run++; if (instr_a !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", instr_a); end
        tests_run++; if (pc_a !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc got %h want 0", pc_a); end
        tests_run++; if (fc_a !== 32'h0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", fc_a); end
        tests_run++; if (addr_a !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", addr_a); end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33;
        rdy_a = 1'b1;
        rst_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                tick();
                tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL fetch%0d_wait%0d_valid got %0b want 0", k, w, valid_a); end
            end
            tick();
            tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL fetch%0d_valid got %0b want 1", k, valid_a); end
            tests_run++; if (pc_a !== 32'(4 * k)) begin tests_failed++; $display("FAIL fetch%0d_pc got %h want %h", k, pc_a, 32'(4 * k)); end
            tests_run++; if (instr_a !== exp_instr[k]) begin tests_failed++; $display("FAIL fetch%0d_instr got %h want %h", k, instr_a, exp_instr[k]); end
        end
        tick();
        tests_run++; if (fc_a !== 32'd3) begin tests_failed++; $display("FAIL fetch_count3 got %0d want 3", fc_a); end
    endtask

    task automatic test_stall();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        rdy_a = 1'b1;
        repeat (6) tick();
        tests_run++; if (valid_a !== 1'b1 || pc_a !== 32'h4) begin tests_failed++; $display("FAIL stall_setup got valid=%0b pc=%h want valid=1 pc=4", valid_a, pc_a); end
        rdy_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL stall%0d_valid got %0b want 1", i, valid_a); end
            tests_run++; if (instr_a !== 32'h22 || pc_a !== 32'h4) begin tests_failed++; $display("FAIL stall%0d_hold got instr=%h pc=%h want 22/4", i, instr_a, pc_a); end
            tests_run++; if (addr_a !== 32'h8) begin tests_failed++; $display("FAIL stall%0d_addr got %h want 8", i, addr_a); end
        end
        rdy_a = 1'b1;
        tick();
        tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL release_valid got %0b want 1", valid_a); end
        tests_run++; if (instr_a !== 32'h33 || pc_a !== 32'h8) begin tests_failed++; $display("FAIL release_data got instr=%h pc=%h want 33/8", instr_a, pc_a); end
        tests_run++; if (fc_a !== 32'd2) begin tests_failed++; $display("FAIL release_count got %0d want 2", fc_a); end
    endtask

    task automatic test_redirect_stalled();
        rdy_a = 1'b0;
        tick();
        tick();
        rv_a = 1'b1;
        rpc_a = 32'h0000_0043;
        tick();
        rv_a = 1'b0;
        tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL redir_flush_valid got %0b want 0", valid_a); end
        tests_run++; if (addr_a !== 32'h40) begin tests_failed++; $display("FAIL redir_addr got %h want 40", addr_a); end
        tests_run++; if (fc_a !== 32'd2) begin tests_failed++; $display("FAIL redir_count got %0d want 2", fc_a); end
        rdy_a = 1'b1;
        for (int w = 0; w < 2; w++) begin
            tick();
            tests_run++; if (valid_a !== 1'b0 || fc_a !== 32'd2) begin tests_failed++; $display("FAIL redir_wait%0d got valid=%0b count=%0d want 0/2", w, valid_a, fc_a); end
        end
        tick();
        tests_run++; if (valid_a !== 1'b1 || pc_a !== 32'h40) begin tests_failed++; $display("FAIL redir_target got valid=%0b pc=%h want 1/40", valid_a, pc_a); end
        tests_run++; if (instr_a !== 32'hA000_0040) begin tests_failed++; $display("FAIL redir_instr got %h want a0000040", instr_a); end
    endtask

    task automatic test_redirect_transfer();
        rv_a = 1'b1;
        rpc_a = 32'h0000_0100;
        tick();
        rv_a = 1'b0;
        tests_run++; if (fc_a !== 32'd3) begin tests_failed++; $display("FAIL redir_xfer_count got %0d want 3", fc_a); end
        tests_run++; if (valid_a !== 1'b0 || addr_a !== 32'h100) begin tests_failed++; $display("FAIL redir_xfer_state got valid=%0b addr=%h want 0/100", valid_a, addr_a); end
    endtask

    task automatic test_redirect_wait();
        tick();
        tests_run++; if (valid_a !== 1'b0 || addr_a !== 32'h100) begin tests_failed++; $display("FAIL wait_cnt1 got valid=%0b addr=%h want 0/100", valid_a, addr_a); end
        rv_a = 1'b1;
        rpc_a = 32'h0000_0200;
        tick();
        rv_a = 1'b0;
        tests_run++; if (valid_a !== 1'b0 || addr_a !== 32'h200) begin tests_failed++; $display("FAIL wait_redir got valid=%0b addr=%h want 0/200", valid_a, addr_a); end
        for (int w = 0; w < 2; w++) begin
            tick();
            tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL wait_settle%0d_valid got %0b want 0", w, valid_a); end
        end
        tick();
        tests_run++; if (valid_a !== 1'b1 || pc_a !== 32'h200) begin tests_failed++; $display("FAIL wait_target got valid=%0b pc=%h want 1/200", valid_a, pc_a); end
        tests_run++; if (instr_a !== 32'hA000_0200 || fc_a !== 32'd3) begin tests_failed++; $display("FAIL wait_data got instr=%h count=%0d want a0000200/3", instr_a, fc_a); end
    endtask

    task automatic test_wrap();
        tests_run++; if (addr_b !== 32'hFFFF_FFFC || valid_b !== 1'b0) begin tests_failed++; $display("FAIL wrap_reset got addr=%h valid=%0b want fffffffc/0", addr_b, valid_b); end
        rdy_b = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        tests_run++; if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_top got valid=%0b pc=%h want 1/fffffffc", valid_b, pc_b); end
        tests_run++; if (instr_b !== 32'h5FFF_FFFC || addr_b !== 32'h0) begin tests_failed++; $display("FAIL wrap_top_data got instr=%h addr=%h want 5ffffffc/0", instr_b, addr_b); end
        repeat (3) tick();
        tests_run++; if (valid_b !== 1'b1 || pc_b !== 32'h0 || instr_b !== 32'h11) begin tests_failed++; $display("FAIL wrap_zero got valid=%0b pc=%h instr=%h want 1/0/11", valid_b, pc_b, instr_b); end
    endtask

    task automatic test_back_to_back_lat1();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33;
        rdy_c = 1'b1;
        rst_c = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++; if (valid_c !== 1'b1) begin tests_failed++; $display("FAIL lat1_%0d_valid got %0b want 1", k, valid_c); end
            tests_run++; if (pc_c !== 32'(4 * k) || instr_c !== exp_instr[k]) begin tests_failed++; $display("FAIL lat1_%0d_data got pc=%h instr=%h want %h/%h", k, pc_c, instr_c, 32'(4 * k), exp_instr[k]); end
            tests_run++; if (fc_c !== 32'(k)) begin tests_failed++; $display("FAIL lat1_%0d_count got %0d want %0d", k, fc_c, k); end
        end
        tick();
        tests_run++; if (fc_c !== 32'd3 || pc_c !== 32'hC) begin tests_failed++; $display("FAIL lat1_3 got count=%0d pc=%h want 3/c", fc_c, pc_c); end
        #2;
        rst_c = 1'b0;
        #1;
        tests_run++; if (valid_c !== 1'b0 || fc_c !== 32'd0) begin tests_failed++; $display("FAIL async_reset got valid=%0b count=%0d want 0/0", valid_c, fc_c); end
        tests_run++; if (addr_c !== 32'h0 || pc_c !== 32'h0) begin tests_failed++; $display("FAIL async_reset_pc got addr=%h if_pc=%h want 0/0", addr_c, pc_c); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_stalled();
        test_redirect_transfer();
        test_redirect_wait();
        test_wrap();
        test_back_to_back_lat1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch-side initiator for the instruction memory: owns the PC, drives the word address to the memory and waits a fixed settle time before sampling the returned instruction.
- Delivers instruction/PC pairs to the IF/ID stage over a valid/ready handshake.
- Handles branch/jump redirects.
- Prefetches the next word while the current one is held by a stalled decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- MEM_LATENCY, 3, number of clock cycles imem_addr must be stable before imem_rdata is valid; legal range 1..15.

Ports:
- clk  input  1  Rising-edge clock.
- rst_n  input  1  Asynchronous, active-low reset.
- imem_addr  output  32  Byte address to instruction memory; always equals the internal PC.
- imem_rdata  input  32  Instruction word returned by memory for imem_addr.
- redirect_valid  input  1  Branch/jump taken this cycle.
- redirect_pc  input  32  Redirect target; bits [1:0] forced to 0.
- if_valid  output  1  if_instr/if_pc hold a valid instruction.
- id_ready  input  1  Decode stage accepts this cycle.
- if_instr  output  32  Fetched instruction.
- if_pc  output  32  Byte address of if_instr.
- fetch_count  output  32  Count of instructions accepted by decode; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync-safe release):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - cnt = 0.
  - if_valid = 0; if_instr = 0; if_pc = 0; fetch_count = 0.
- State: output register EMPTY (if_valid=0) or FULL (if_valid=1), plus settle counter cnt of width ceil(log2(MEM_LATENCY)) (minimum 1 bit).
- Settle counter:
  - cnt is cleared on every pc change.
  - Otherwise cnt increments, saturating at MEM_LATENCY-1.
  - data_ok = (cnt == MEM_LATENCY-1). With MEM_LATENCY=1, data_ok is always 1.
- transfer = if_valid & id_ready.
- capture = data_ok & (!if_valid | id_ready) & !redirect_valid.
- Priority at each rising edge:
  1. Redirect (redirect_valid=1):
     - pc <= {redirect_pc[31:2],2'b00}; cnt <= 0; if_valid <= 0 (flush, even if FULL and stalled).
     - A same-cycle transfer still counts in fetch_count.
  2. Capture:
     - if_instr <= imem_rdata; if_pc <= pc; if_valid <= 1.
     - pc <= pc+4; cnt <= 0.
     - Enables back-to-back delivery when the prefetched word is ready at transfer.
  3. Transfer without capture: if_valid <= 0.
  4. Otherwise: outputs hold; cnt advances.
- Stall (FULL & !id_ready):
  - if_instr/if_pc stay bit-stable.
  - pc stays unchanged and the counter saturates, so the prefetched word is ready at release.
- Throughput:
  - Steady state with id_ready=1: one instruction every MEM_LATENCY cycles.
  - First if_valid after reset or redirect: MEM_LATENCY cycles later.
- fetch_count increments by 1 on every transfer.
- PC arithmetic: 32-bit unsigned, so 32'hFFFF_FFFC + 4 wraps to 0. No misaligned fetch is ever issued.
- Reset asserted mid-wait or mid-stall: immediate return to reset values; the in-flight fetch is discarded.
- Redirect while EMPTY and counting: old fetch abandoned; counting restarts from 0 at the new address.

Test Plan:
- Reset, MEM_LATENCY=3, id_ready=1, memory words 0x11,0x22,0x33 at 0,4,8:
  - if_valid rises 3 cycles after reset release with if_pc=0, if_instr=0x11.
  - Then if_pc=4/0x22 and 8/0x33 at 3-cycle spacing.
  - fetch_count=3 after the third transfer.
- Stall: hold id_ready=0 for 6 cycles while FULL at pc 4:
  - if_instr=0x22 held stable.
  - imem_addr=8 constant.
  - On release, 0x33 appears the very next cycle (prefetch ready).
- Redirect while FULL and stalled, redirect_pc=0x00000043:
  - if_valid=0 next cycle; imem_addr=0x40.
  - After 3 cycles if_pc=0x40.
  - Stale instruction never accepted; fetch_count unchanged.
- Redirect during the settle wait (cnt=1):
  - No capture of the old address.
  - New instruction valid exactly 3 cycles after the redirect edge.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, id_ready=1 -> if_pc=FFFF_FFFC, then if_pc=0.
- MEM_LATENCY=1, id_ready=1 -> one instruction every cycle. Assert rst_n low mid-stream -> if_valid and fetch_count clear immediately (asynchronously).
